cross_sensor_conditioner: RTL

//  Upstream stage of the intersection light FSM. Conditions the raw cross-road vehicle loop detector and produces the clean request that drives the FSM's sensor input C.
//  - Synchronises and debounces the detector.
//  - Requires a dwell time before requesting, so pass-through vehicles do not trigger a request.
//  - Holds the request until the FSM grants cross green.
//  - Counts departed vehicles and flags a stuck detector.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/sensor_debounce.sv | 39 +++
 rtl/cross_sensor_conditioner.sv | 103 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - request-FSM state codes and light encodings shared with the intersection light FSM
package traffic_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DWELL  = 2'd1;
    localparam logic [1:0] ST_REQ    = 2'd2;
    localparam logic [1:0] ST_SERVED = 2'd3;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchroniser plus stable-count debounce for an asynchronous contact input
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            meta;
    logic            sync_q;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            db_cnt <= '0;
            dout   <= 1'b0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            // Any return to the current output level restarts the stability window.
            if (sync_q == dout) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                dout   <= sync_q;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cross_sensor_conditioner.sv
// rtl/cross_sensor_conditioner.sv - cross-road detector conditioning: debounce, dwell-qualified request,
// vehicle count and stuck-detector fault feeding the light FSM sensor input C
module cross_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned     DEBOUNCE_CYC = 500_000,
    parameter int unsigned     DWELL_CYC    = 100_000_000,
    parameter longint unsigned STUCK_CYC    = 64'd3_000_000_000,
    parameter int unsigned     CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
    input  logic             cross_green,
    input  logic             cnt_clr,
    output logic             cross_req,
    output logic             sensor_clean,
    output logic [CNT_W-1:0] veh_count,
    output logic             fault
);

    localparam int DW_W = $clog2(DWELL_CYC + 1);
    localparam int ST_W = $clog2(STUCK_CYC + 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYC - 1);
    localparam logic [ST_W-1:0]  STUCK_LAST = ST_W'(STUCK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [DW_W-1:0] dwell_cnt;
    logic [ST_W-1:0] stuck_cnt;
    logic            clean_q;
    logic            clean_fall;

    sensor_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (sensor_raw),
        .dout (sensor_clean)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (sensor_clean) state_next = ST_DWELL;
            // A detector drop ends the dwell even on the terminal count.
            ST_DWELL:  if (!sensor_clean)             state_next = ST_IDLE;
                       else if (dwell_cnt == DWELL_LAST) state_next = ST_REQ;
            ST_REQ:    if (cross_green)  state_next = ST_SERVED;
            ST_SERVED: if (!cross_green) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dwell_cnt <= '0;
            cross_req <= 1'b0;
        end else begin
            state     <= state_next;
            cross_req <= (state_next == ST_REQ);
            if (state == ST_DWELL && state_next == ST_DWELL) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end else begin
                dwell_cnt <= '0;
            end
        end
    end

    assign clean_fall = clean_q & ~sensor_clean;

    always_ff @(posedge clk) begin
        if (rst) begin
            clean_q   <= 1'b0;
            veh_count <= '0;
        end else begin
            clean_q <= sensor_clean;
            if (cnt_clr) begin
                veh_count <= '0;
            end else if (clean_fall && veh_count != CNT_MAX) begin
                veh_count <= veh_count + 1'b1;
            end
        end
    end

    // Fault is sticky; only reset clears it, and it never feeds back into the request FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_cnt <= '0;
            fault     <= 1'b0;
        end else if (!sensor_clean) begin
            stuck_cnt <= '0;
        end else if (stuck_cnt == STUCK_LAST) begin
            fault <= 1'b1;
        end else begin
            stuck_cnt <= stuck_cnt + 1'b1;
        end
    end

endmodule
